// File: rtl/id_hazard_ctrl_pkg.sv
// Shared types for the ID-stage hazard controller: forward-select encoding and scoreboard slot.
package id_hazard_ctrl_pkg;

  localparam int unsigned SLOT_RD_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10
  } fwd_sel_type;

  typedef struct packed {
    logic                 valid;
    logic [SLOT_RD_W-1:0] rd;
    logic                 is_load;
  } hazard_slot_type;

  // Youngest producer wins: the EX-slot match takes precedence over the MEM-slot match.
  function automatic fwd_sel_type fwd_pick(input logic ex_match, input logic mem_match);
    if (ex_match)       return FWD_EX_MEM;
    else if (mem_match) return FWD_MEM_WB;
    else                return FWD_NONE;
  endfunction

endpackage

// File: rtl/id_hazard_ctrl_scoreboard.sv
// EX/MEM destination scoreboard: shifts on every non-frozen edge, accepts a bubble or the ID
// instruction into EX, and reports per-source matches against both slots.
module hazard_scoreboard
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  freeze,
  input  logic                  bubble,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  output logic                  ex_is_load,
  output logic                  ex_rs1_match,
  output logic                  ex_rs2_match,
  output logic                  mem_rs1_match,
  output logic                  mem_rs2_match
);

  hazard_slot_type ex_slot;
  hazard_slot_type mem_slot;
  hazard_slot_type new_entry;

  // Only real writes to a non-zero register occupy a slot, so x0 can never match.
  always_comb begin
    new_entry         = '0;
    new_entry.valid   = !bubble && id_reg_write && (id_rd != '0);
    new_entry.rd      = SLOT_RD_W'(id_rd);
    new_entry.is_load = id_is_load;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else if (!freeze) begin
      mem_slot <= ex_slot;
      ex_slot  <= new_entry;
    end
  end

  assign ex_is_load    = ex_slot.is_load;
  assign ex_rs1_match  = id_valid && id_rs1_used && ex_slot.valid  && (ex_slot.rd  == SLOT_RD_W'(id_rs1));
  assign ex_rs2_match  = id_valid && id_rs2_used && ex_slot.valid  && (ex_slot.rd  == SLOT_RD_W'(id_rs2));
  assign mem_rs1_match = id_valid && id_rs1_used && mem_slot.valid && (mem_slot.rd == SLOT_RD_W'(id_rs1));
  assign mem_rs2_match = id_valid && id_rs2_used && mem_slot.valid && (mem_slot.rd == SLOT_RD_W'(id_rs2));

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard/sequencing controller: stall, flush and bubble control plus counters.
// Define ID_HAZARD_FORWARD_EN to build the forwarding selects (stall only on load-use).
module id_hazard_ctrl
  import id_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  ex_mispredict,
  input  logic                  mem_stall,
  output logic                  stall_pc,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

`ifdef ID_HAZARD_FORWARD_EN
  localparam bit FULL_INTERLOCK = 1'b0;
`else
  localparam bit FULL_INTERLOCK = 1'b1;
`endif

  logic ex_is_load;
  logic ex_rs1_match, ex_rs2_match;
  logic mem_rs1_match, mem_rs2_match;
  logic hazard;

  hazard_scoreboard #(.REG_ADDR_W(REG_ADDR_W)) u_scoreboard (
    .clk          (clk),
    .rstn         (rstn),
    .freeze       (mem_stall),
    .bubble       (bubble_ex || !id_valid),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .ex_is_load   (ex_is_load),
    .ex_rs1_match (ex_rs1_match),
    .ex_rs2_match (ex_rs2_match),
    .mem_rs1_match(mem_rs1_match),
    .mem_rs2_match(mem_rs2_match)
  );

  // With forwarding only a load in EX blocks; a full interlock blocks on any EX/MEM producer.
  assign hazard = ((ex_rs1_match || ex_rs2_match) && (ex_is_load || FULL_INTERLOCK)) ||
                  ((mem_rs1_match || mem_rs2_match) && FULL_INTERLOCK);

  // Priority: mem_stall > ex_mispredict > hazard > advance.
  always_comb begin
    stall_pc  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    if (mem_stall) begin
      stall_pc = 1'b1;
    end else if (ex_mispredict) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (hazard) begin
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!mem_stall) begin
      if (ex_mispredict)  flush_cnt <= flush_cnt + CNT_W'(1);
      else if (hazard)    stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef ID_HAZARD_FORWARD_EN
  fwd_sel_type fwd_a_q, fwd_b_q;

  // Selects follow the instruction into EX; a bubble carries no operands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else if (!mem_stall) begin
      if (bubble_ex) begin
        fwd_a_q <= FWD_NONE;
        fwd_b_q <= FWD_NONE;
      end else begin
        fwd_a_q <= fwd_pick(ex_rs1_match, mem_rs1_match);
        fwd_b_q <= fwd_pick(ex_rs2_match, mem_rs2_match);
      end
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
`else
  assign fwd_a_sel = FWD_NONE;
  assign fwd_b_sel = FWD_NONE;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Self-checking bench for id_hazard_ctrl; reference model tracks per-register producer age.
module tb_id_hazard_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned CW = 32;
`ifdef ID_HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic          id_reg_write = 1'b0, id_is_load = 1'b0;
  logic          ex_mispredict = 1'b0, mem_stall = 1'b0;
  logic          stall_pc, bubble_ex, flush_id;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  id_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_mispredict(ex_mispredict),
    .mem_stall(mem_stall), .stall_pc(stall_pc), .bubble_ex(bubble_ex), .flush_id(flush_id),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: t counts pipeline advances; last_tick[r] is the advance at which r's youngest
  // producer entered EX. Age 0 means it is in EX now, age 1 means it is in MEM.
  int   last_tick [32];
  bit   last_load [32];
  int   t;
  int   m_stall_cnt, m_flush_cnt;
  logic [1:0] m_fa, m_fb;
  logic last_stall;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      last_tick[i] = -100;
      last_load[i] = 1'b0;
    end
    t = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_fa = 2'b00; m_fb = 2'b00;
  endtask

  function automatic bit src_hazard(input logic v, input logic used, input int s);
    int age;
    if (!v || !used || s == 0) return 1'b0;
    age = t - last_tick[s];
    if (FWD) return (age == 0) && last_load[s];
    return (age == 0) || (age == 1);
  endfunction

  function automatic logic [1:0] src_fwd(input logic v, input logic used, input int s);
    int age;
    if (!v || !used || s == 0) return 2'b00;
    age = t - last_tick[s];
    if (age == 0) return 2'b01;
    if (age == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input int r1, input int r2, input logic u1, input logic u2,
                      input int rd, input logic rw, input logic ld, input logic mis, input logic ms);
    bit haz;
    @(negedge clk);
    id_valid = v; id_rs1 = RW'(r1); id_rs2 = RW'(r2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = RW'(rd); id_reg_write = rw; id_is_load = ld; ex_mispredict = mis; mem_stall = ms;
    #1;
    haz = src_hazard(v, u1, r1) || src_hazard(v, u2, r2);
    last_stall = ms || (!mis && haz);
    chk("stall_pc",  32'(stall_pc),  32'(last_stall));
    chk("bubble_ex", 32'(bubble_ex), 32'(!ms && (mis || haz)));
    chk("flush_id",  32'(flush_id),  32'(!ms && mis));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(m_fa));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(m_fb));
    chk("stall_cnt", stall_cnt,      32'(m_stall_cnt));
    chk("flush_cnt", flush_cnt,      32'(m_flush_cnt));
    if (!ms) begin
      if (mis || haz) begin
        if (mis) m_flush_cnt++; else m_stall_cnt++;
        m_fa = 2'b00; m_fb = 2'b00;
      end else begin
        m_fa = FWD ? src_fwd(v, u1, r1) : 2'b00;
        m_fb = FWD ? src_fwd(v, u2, r2) : 2'b00;
        if (v && rw && rd != 0) begin
          last_tick[rd] = t + 1;
          last_load[rd] = ld;
        end
      end
      t++;
    end
  endtask

  // Present an instruction and hold it in ID until it is accepted (or killed by mispredict).
  task automatic issue(input logic v, input int r1, input int r2, input logic u1, input logic u2,
                       input int rd, input logic rw, input logic ld, input logic mis, input logic ms);
    int n = 0;
    step(v, r1, r2, u1, u2, rd, rw, ld, mis, ms);
    while (last_stall && n < 20) begin
      step(v, r1, r2, u1, u2, rd, rw, ld, 1'b0, (n < 3) && ($urandom_range(4) == 0));
      n++;
    end
    if (last_stall) begin
      checks++; errors++;
      $error("FAIL issue_timeout observed=stalled expected=accepted");
    end
  endtask

  task automatic alu(input int rd, input int r1, input int r2);
    issue(1, r1, r2, 1, 1, rd, 1, 0, 0, 0);
  endtask

  task automatic load(input int rd, input int r1);
    issue(1, r1, 0, 1, 0, rd, 1, 1, 0, 0);
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #3;
    chk("rst_stall_pc", 32'(stall_pc), 32'd0);
    chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Load-use, ALU back-to-back, ALU with one instruction between.
    load(5, 1); alu(6, 5, 1); nop(); nop();
    alu(5, 1, 2); alu(7, 1, 5); nop(); nop();
    alu(5, 1, 2); alu(8, 3, 4); alu(7, 1, 5); nop(); nop();
    alu(5, 1, 2); alu(6, 5, 5); nop(); nop();

    // Mispredict coinciding with a hazard.
    load(5, 1);
    step(1, 5, 1, 1, 1, 6, 1, 0, 1, 0);
    chk("mis_stall_pc", 32'(stall_pc), 32'd0);
    chk("mis_flush_id", 32'(flush_id), 32'd1);
    nop(); nop();

    // mem_stall held across a load-use.
    load(5, 1);
    repeat (3) step(1, 5, 1, 1, 1, 6, 1, 0, 0, 1);
    alu(6, 5, 1); nop(); nop();

    // x0 producer and x0 consumer.
    alu(0, 1, 2); alu(6, 0, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
    chk("x0_no_stall", 32'(stall_pc), 32'd0);
    nop(); nop();

    // Reset pulse while a hazard is being held.
    load(5, 1);
    step(1, 5, 2, 1, 1, 6, 1, 0, 0, 0);
    #1 rstn = 1'b0;
    #1;
    chk("rst_mid_stall_pc",  32'(stall_pc),  32'd0);
    chk("rst_mid_bubble_ex", 32'(bubble_ex), 32'd0);
    chk("rst_mid_flush_id",  32'(flush_id),  32'd0);
    chk("rst_mid_fwd_b",     32'(fwd_b_sel), 32'd0);
    chk("rst_mid_stall_cnt", stall_cnt,      32'd0);
    chk("rst_mid_flush_cnt", flush_cnt,      32'd0);
    model_reset();
    @(negedge clk); rstn = 1'b1;

    // Randomized traffic over a small register set to provoke frequent dependencies.
    for (int i = 0; i < 1500; i++) begin
      issue($urandom_range(7) != 0, $urandom_range(7), $urandom_range(7),
            $urandom_range(1), $urandom_range(1), $urandom_range(7),
            $urandom_range(3) != 0, $urandom_range(2) == 0,
            $urandom_range(9) == 0, $urandom_range(6) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
